// File: rtl/lbp_pkg.sv
// Shared state encoding, neighbour bit positions and code width for the LBP stream engine.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LBP_W = 8;

    // Bit position of each neighbour in the LBP code, raster order around the center.
    localparam int K_TL = 0;
    localparam int K_T  = 1;
    localparam int K_TR = 2;
    localparam int K_L  = 3;
    localparam int K_R  = 4;
    localparam int K_BL = 5;
    localparam int K_B  = 6;
    localparam int K_BR = 7;

endpackage

// File: rtl/lbp_line_buffer.sv
// Two IMG_W-deep row stores: on each captured pixel, the column's mid value moves to top and the
// new pixel becomes mid. The pre-write values form the upper two rows of the window column.
module lbp_line_buffer #(
    parameter int IMG_W = 128,
    parameter int PIX_W = 8,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] top,
    output logic [PIX_W-1:0] mid
);

    logic [PIX_W-1:0] top_mem [IMG_W];
    logic [PIX_W-1:0] mid_mem [IMG_W];

    assign top = top_mem[col];
    assign mid = mid_mem[col];

    // Contents are meaningless until two rows have streamed through; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            top_mem[col] <= mid_mem[col];
            mid_mem[col] <= din;
        end
    end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: single raster fetch, line buffers plus sliding window, 2-cycle request-to-write.
// Optional LBP_BORDER_WRITE_EN: also write 8'h00 for every border pixel, addresses strictly increasing.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    input  logic              gray_ready,
    input  logic [PIX_W-1:0]  gray_data,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic [LBP_W-1:0]  lbp_data,
    output logic              finish
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_REQ = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] ROW2     = ADDR_W'(2 * IMG_W);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL2     = COL_W'(2);
`ifdef LBP_BORDER_WRITE_EN
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(IMG_W * IMG_H - 1);
`else
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
`endif

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          gray_addr_q, gray_addr_d;
    logic                       cap_q, cap_d;
    logic [ADDR_W-1:0]          cap_addr_q, cap_addr_d;
    logic [COL_W-1:0]           cap_col_q, cap_col_d;
    logic [2:0][PIX_W-1:0]      win1_q, win1_d, win2_q, win2_d;   // [0]=top [1]=mid [2]=bottom
    logic                       lbp_valid_q, lbp_valid_d;
    logic [ADDR_W-1:0]          lbp_addr_q, lbp_addr_d;
    logic [LBP_W-1:0]           lbp_data_q, lbp_data_d;
    logic                       finish_q, finish_d;

    logic [PIX_W-1:0]           lb_top, lb_mid;
    logic [LBP_W-1:0][PIX_W-1:0] nb;
    logic [LBP_W-1:0]           code;
    logic                       interior;

    assign gray_req  = (state_q == FETCH) && gray_ready;
    assign gray_addr = gray_addr_q;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_valid = lbp_valid_q;
    assign lbp_data  = lbp_data_q;
    assign finish    = finish_q;

    lbp_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W), .COL_W(COL_W)) u_lbuf (
        .clk   (clk),
        .wr_en (cap_q),
        .col   (cap_col_q),
        .din   (gray_data),
        .top   (lb_top),
        .mid   (lb_mid)
    );

    // Window at capture of (r,c): win2 = column c-2, win1 = column c-1, line buffer + gray_data = column c.
    always_comb begin
        nb[K_TL] = win2_q[0];
        nb[K_T]  = win1_q[0];
        nb[K_TR] = lb_top;
        nb[K_L]  = win2_q[1];
        nb[K_R]  = lb_mid;
        nb[K_BL] = win2_q[2];
        nb[K_B]  = win1_q[2];
        nb[K_BR] = gray_data;
        for (int k = 0; k < LBP_W; k++) code[k] = (nb[k] >= win1_q[1]);
    end

    // c>=2 gating also guarantees stale columns from the previous row never reach an output.
    assign interior = cap_q && (cap_addr_q >= ROW2) && (cap_col_q >= COL2);

    always_comb begin
        state_d     = state_q;
        gray_addr_d = gray_addr_q;
        finish_d    = finish_q;
        cap_d       = gray_req;
        cap_addr_d  = cap_addr_q;
        cap_col_d   = cap_col_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;

        case (state_q)
            IDLE:  if (gray_ready) state_d = FETCH;
            FETCH: if (gray_req) begin
                       if (gray_addr_q == LAST_REQ) state_d = DRAIN;
                       else gray_addr_d = gray_addr_q + 1'b1;
                   end
            DRAIN: if (lbp_valid_q && lbp_addr_q == LAST_WR) begin
                       state_d  = DONE;
                       finish_d = 1'b1;
                   end
            default: ;
        endcase

        if (cap_q) begin
            cap_addr_d = cap_addr_q + 1'b1;
            cap_col_d  = (cap_col_q == LAST_COL) ? '0 : cap_col_q + 1'b1;
            win2_d     = win1_q;
            win1_d     = {gray_data, lb_mid, lb_top};
        end

`ifdef LBP_BORDER_WRITE_EN
        // Each capture retires the pixel one row and one column behind it; the tail is flushed in DRAIN.
        if (cap_q && cap_addr_q >= CTR_OFS) begin
            lbp_valid_d = 1'b1;
            lbp_addr_d  = cap_addr_q - CTR_OFS;
            lbp_data_d  = interior ? code : '0;
        end else if (state_q == DRAIN && lbp_addr_q != LAST_WR) begin
            lbp_valid_d = 1'b1;
            lbp_addr_d  = lbp_addr_q + 1'b1;
            lbp_data_d  = '0;
        end
`else
        if (interior) begin
            lbp_valid_d = 1'b1;
            lbp_addr_d  = cap_addr_q - CTR_OFS;
            lbp_data_d  = code;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gray_addr_q <= '0;
            cap_q       <= 1'b0;
            cap_addr_q  <= '0;
            cap_col_q   <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gray_addr_q <= gray_addr_d;
            cap_q       <= cap_d;
            cap_addr_q  <= cap_addr_d;
            cap_col_q   <= cap_col_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
        end
    end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Self-checking bench: a 4x4 engine for the directed/stall/reset scenarios and a default 128x128 engine
// for a random frame, both compared against a neighbourhood-level LBP model.
module tb_lbp_stream_engine;

    localparam int AW = 4, AH = 4, AAW = 4, AN = AW * AH;
    localparam int BW = 128, BH = 128, BAW = 14, BN = BW * BH;
`ifdef LBP_BORDER_WRITE_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;

    // ---------------- 4x4 instance ----------------
    logic           rst_a = 1'b1, ga_req, ga_ready = 1'b0, la_valid, fin_a;
    logic [AAW-1:0] ga_addr, la_addr;
    logic [7:0]     ga_data, la_data;

    lbp_stream_engine #(.IMG_W(AW), .IMG_H(AH), .ADDR_W(AAW), .PIX_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .gray_addr(ga_addr), .gray_req(ga_req), .gray_ready(ga_ready),
        .gray_data(ga_data), .lbp_addr(la_addr), .lbp_valid(la_valid), .lbp_data(la_data), .finish(fin_a)
    );

    // ---------------- 128x128 instance ----------------
    logic           rst_b = 1'b1, gb_req, gb_ready = 1'b0, lb_valid, fin_b;
    logic [BAW-1:0] gb_addr, lb_addr;
    logic [7:0]     gb_data, lb_data;

    lbp_stream_engine dut_b (
        .clk(clk), .reset(rst_b), .gray_addr(gb_addr), .gray_req(gb_req), .gray_ready(gb_ready),
        .gray_data(gb_data), .lbp_addr(lb_addr), .lbp_valid(lb_valid), .lbp_data(lb_data), .finish(fin_b)
    );

    int img_a[], img_b[], ra_cyc[];
    int wa_addr[$], wa_data[$], wa_cyc[$], wb_addr[$], wb_data[$];
    int fina_cyc = -1, finb_cyc = -1;
    int ea[$], ed[$];

    // Memory responders: data for a request appears the following cycle; junk otherwise.
    initial begin : feed_a
        bit r; int a;
        ga_data = 8'd0;
        forever begin
            @(negedge clk); r = ga_req; a = int'(ga_addr);
            if (r && ra_cyc.size() == AN) ra_cyc[a] = cyc;
            @(posedge clk); #1;
            ga_data = r ? 8'(img_a[a]) : 8'($urandom);
        end
    end

    initial begin : feed_b
        bit r; int a;
        gb_data = 8'd0;
        forever begin
            @(negedge clk); r = gb_req; a = int'(gb_addr);
            @(posedge clk); #1;
            gb_data = r ? 8'(img_b[a]) : 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (la_valid) begin
            wa_addr.push_back(int'(la_addr)); wa_data.push_back(int'(la_data)); wa_cyc.push_back(cyc);
        end
        if (fin_a && fina_cyc < 0) fina_cyc = cyc;
        if (lb_valid) begin
            wb_addr.push_back(int'(lb_addr)); wb_data.push_back(int'(lb_data));
        end
        if (fin_b && finb_cyc < 0) finb_cyc = cyc;
    end

    // Reference: every pixel in address order, code from its eight neighbours in raster order.
    function automatic void lbp_model(input int w, input int h, input int img[], input bit border,
                                      output int qa[$], output int qd[$]);
        int r, c, code, k;
        qa = {}; qd = {};
        for (int p = 0; p < w * h; p++) begin
            r = p / w; c = p % w;
            if (r > 0 && r < h - 1 && c > 0 && c < w - 1) begin
                code = 0; k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        if (img[(r + dr) * w + c + dc] >= img[p]) code |= (1 << k);
                        k++;
                    end
                qa.push_back(p); qd.push_back(code);
            end else if (border) begin
                qa.push_back(p); qd.push_back(0);
            end
        end
    endfunction

    task automatic reset_a();
        ga_ready = 1'b0; rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wa_addr = {}; wa_data = {}; wa_cyc = {}; fina_cyc = -1;
        ra_cyc = new[AN]; foreach (ra_cyc[i]) ra_cyc[i] = -1;
        rst_a = 1'b0;
    endtask

    task automatic frame_a(input bit rnd_ready, output bit tmo);
        reset_a();
        tmo = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            ga_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (fin_a) begin tmo = 1'b0; break; end
        end
        ga_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; ga_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ga_addr !== '0 || ga_req !== 1'b0) begin errors++;
            $display("FAIL reset_fetch got addr=%0d req=%0b want 0/0", ga_addr, ga_req); end
        checks++; if (la_valid !== 1'b0 || la_addr !== '0 || la_data !== 8'd0 || fin_a !== 1'b0) begin errors++;
            $display("FAIL reset_out got v=%0b a=%0d d=%0h f=%0b want all 0", la_valid, la_addr, la_data, fin_a); end
        ga_ready = 1'b0;
    endtask

    task automatic test_flat();
        bit tmo;
        img_a = new[AN]; foreach (img_a[i]) img_a[i] = 50;
        frame_a(1'b0, tmo);
        lbp_model(AW, AH, img_a, BORDER, ea, ed);
        checks++; if (tmo) begin errors++; $display("FAIL flat_timeout got no finish want finish"); end
        checks++; if (wa_addr.size() != ea.size()) begin errors++;
            $display("FAIL flat_count got %0d want %0d", wa_addr.size(), ea.size()); end
        else foreach (ea[i]) begin
            checks++; if (wa_addr[i] !== ea[i] || wa_data[i] !== ed[i]) begin errors++;
                $display("FAIL flat_write[%0d] got %0d/%0h want %0d/%0h", i, wa_addr[i], wa_data[i], ea[i], ed[i]); end
        end
        checks++; if (wa_cyc.size() == 0 || fina_cyc !== wa_cyc[$] + 1) begin errors++;
            $display("FAIL flat_finish_cycle got %0d want one after last write", fina_cyc); end
        checks++; if (fin_a !== 1'b1) begin errors++; $display("FAIL flat_finish_held got %0b want 1", fin_a); end
    endtask

    task automatic test_ramp();
        bit tmo; int a;
        img_a = new[AN]; foreach (img_a[i]) img_a[i] = i;
        frame_a(1'b0, tmo);
        lbp_model(AW, AH, img_a, BORDER, ea, ed);
        checks++; if (tmo) begin errors++; $display("FAIL ramp_timeout got no finish want finish"); end
        checks++; if (wa_addr.size() != ea.size()) begin errors++;
            $display("FAIL ramp_count got %0d want %0d", wa_addr.size(), ea.size()); end
        else foreach (ea[i]) begin
            checks++; if (wa_addr[i] !== ea[i] || wa_data[i] !== ed[i]) begin errors++;
                $display("FAIL ramp_write[%0d] got %0d/%0h want %0d/%0h", i, wa_addr[i], wa_data[i], ea[i], ed[i]); end
        end
        // A write for pixel a depends on the fetch of a+W+1 and lands exactly 2 cycles after it.
        foreach (wa_addr[i]) begin
            a = wa_addr[i] + AW + 1;
            if (a < AN) begin
                checks++; if (wa_cyc[i] !== ra_cyc[a] + 2) begin errors++;
                    $display("FAIL ramp_latency addr %0d got cycle %0d want %0d", wa_addr[i], wa_cyc[i], ra_cyc[a] + 2); end
            end
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        bit done = 1'b0;
        img_a = new[AN]; foreach (img_a[i]) img_a[i] = i;
        reset_a();
        for (int k = 0; k < 400 && !done; k++) begin
            ga_ready = (k % 5) < 2;
            @(negedge clk);
            if (!ga_ready) begin
                checks++; if (ga_req !== 1'b0) begin errors++; $display("FAIL stall_req got 1 want 0 (cycle %0d)", cyc); end
            end
            if (nreq < AN) begin
                checks++; if (int'(ga_addr) !== nreq) begin errors++;
                    $display("FAIL stall_addr got %0d want %0d", ga_addr, nreq); end
            end
            if (ga_req) nreq++;
            done = fin_a;
            @(posedge clk); #1;
        end
        ga_ready = 1'b0;
        lbp_model(AW, AH, img_a, BORDER, ea, ed);
        checks++; if (!done || nreq != AN) begin errors++;
            $display("FAIL stall_frame got finish=%0b requests=%0d want 1/%0d", done, nreq, AN); end
        checks++; if (wa_addr.size() != ea.size()) begin errors++;
            $display("FAIL stall_count got %0d want %0d", wa_addr.size(), ea.size()); end
        else foreach (ea[i]) begin
            checks++; if (wa_addr[i] !== ea[i] || wa_data[i] !== ed[i]) begin errors++;
                $display("FAIL stall_write[%0d] got %0d/%0h want %0d/%0h", i, wa_addr[i], wa_data[i], ea[i], ed[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit tmo;
        img_a = new[AN]; foreach (img_a[i]) img_a[i] = i;
        reset_a();
        ga_ready = 1'b1;
        for (int k = 0; k < 50 && ra_cyc[7] < 0; k++) begin @(posedge clk); #1; end
        checks++; if (ra_cyc[7] < 0) begin errors++; $display("FAIL midreset_reach got no request for 7 want one"); end
        rst_a = 1'b1; #1;
        checks++; if (ga_addr !== '0 || ga_req !== 1'b0 || la_valid !== 1'b0 || la_addr !== '0 ||
                      la_data !== 8'd0 || fin_a !== 1'b0) begin errors++;
            $display("FAIL midreset_outputs got a=%0d r=%0b v=%0b la=%0d d=%0h f=%0b want all 0",
                     ga_addr, ga_req, la_valid, la_addr, la_data, fin_a); end
        frame_a(1'b0, tmo);
        lbp_model(AW, AH, img_a, BORDER, ea, ed);
        checks++; if (tmo || wa_addr.size() != ea.size()) begin errors++;
            $display("FAIL midreset_count got %0d (timeout=%0b) want %0d", wa_addr.size(), tmo, ea.size()); end
        else foreach (ea[i]) begin
            checks++; if (wa_addr[i] !== ea[i] || wa_data[i] !== ed[i]) begin errors++;
                $display("FAIL midreset_write[%0d] got %0d/%0h want %0d/%0h", i, wa_addr[i], wa_data[i], ea[i], ed[i]); end
        end
    endtask

    // Small value range forces many equal-neighbour ties on the >= boundary.
    task automatic test_random_small();
        bit tmo;
        for (int it = 0; it < 4; it++) begin
            img_a = new[AN]; foreach (img_a[i]) img_a[i] = (it == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            frame_a(1'b1, tmo);
            lbp_model(AW, AH, img_a, BORDER, ea, ed);
            checks++; if (tmo || wa_addr.size() != ea.size()) begin errors++;
                $display("FAIL rand%0d_count got %0d (timeout=%0b) want %0d", it, wa_addr.size(), tmo, ea.size()); end
            else foreach (ea[i]) begin
                checks++; if (wa_addr[i] !== ea[i] || wa_data[i] !== ed[i]) begin errors++;
                    $display("FAIL rand%0d_write[%0d] got %0d/%0h want %0d/%0h", it, i, wa_addr[i], wa_data[i], ea[i], ed[i]); end
            end
            checks++; if (wa_cyc.size() == 0 || fina_cyc !== wa_cyc[$] + 1) begin errors++;
                $display("FAIL rand%0d_finish got %0d want one after last write", it, fina_cyc); end
        end
    endtask

    task automatic test_big();
        bit tmo = 1'b1;
        int nerr = 0;
        img_b = new[BN]; foreach (img_b[i]) img_b[i] = int'($urandom_range(0, 255));
        gb_ready = 1'b0; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_addr = {}; wb_data = {}; finb_cyc = -1;
        rst_b = 1'b0; gb_ready = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk); #1;
            if (fin_b) begin tmo = 1'b0; break; end
        end
        repeat (5) @(posedge clk);
        #1;
        lbp_model(BW, BH, img_b, BORDER, ea, ed);
        checks++; if (tmo || wb_addr.size() != ea.size()) begin errors++;
            $display("FAIL big_count got %0d (timeout=%0b) want %0d", wb_addr.size(), tmo, ea.size()); end
        else foreach (ea[i]) begin
            checks++; if (wb_addr[i] !== ea[i] || wb_data[i] !== ed[i]) begin errors++; nerr++;
                if (nerr <= 10) $display("FAIL big_write[%0d] got %0d/%0h want %0d/%0h", i, wb_addr[i], wb_data[i], ea[i], ed[i]); end
        end
        checks++; if (fin_b !== 1'b1) begin errors++; $display("FAIL big_finish_held got %0b want 1", fin_b); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_stall();
        test_reset_midframe();
        test_random_small();
        test_big();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
